gerador_varredura: RTL and testbench
====================================

Name: gerador_varredura

Overview:
- Column-scan sequencer for the 8x8 LED matrix.
- Produces the 3-bit column index that drives the team's 3-to-8 column decoder, plus the 8-bit row pattern for the selected column.
- Inserts a blanking gap between columns to prevent ghosting.
- Holds a double-buffered 64-bit frame loaded by a one-cycle request/acknowledge handshake; buffers swap only at frame boundaries.

Parameters:
DIV, 50000, clock cycles each column is displayed (>=2)
BLANK, 2, clock cycles of blanking between columns (>=2)
NUM_COL, 8, columns scanned per frame (1..8)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  scan enable; 0 forces idle
frame_ld  in  1  request to load frame_in
frame_in  in  64  frame; column k = bits [8k+7:8k], bit r = row r
frame_ack  out  1  one-cycle pulse: frame_in captured
sel  out  3  column index to the column decoder
col_dado  out  8  row pattern of column sel (active buffer)
blank  out  1  1 = column drivers must be off
fim_quadro  out  1  one-cycle pulse on frame wrap

Behaviour:
- Only one clock and one reset; rst is synchronous and active-high; all outputs registered.
- Reset values:
  - State OCIOSO; prescaler and blank counter 0.
  - sel=0, col_dado=0, blank=1, frame_ack=0, fim_quadro=0.
  - Active and pending buffers 0; pendente=0.
- States:
  - OCIOSO: blank=1, sel=0, prescaler held at 0. When en=1, next edge enters EXIBE: blank=0, sel=0, col_dado=active[7:0].
  - EXIBE: prescaler counts 0..DIV-1. When it reaches DIV-1, next edge enters APAGA with blank=1 and blank counter=0. The column is lit for exactly DIV cycles.
  - APAGA: blank counter counts 0..BLANK-1.
    - The edge ending APAGA cycle 0 advances sel: sel+1, or 0 if sel==NUM_COL-1. col_dado updates on the same edge.
    - When the counter reaches BLANK-1, next edge enters EXIBE with blank=0 and prescaler=0.
    - sel is therefore stable for at least 1 cycle before blank falls and never changes while blank=0.
  - Column period is DIV+BLANK cycles; frame period is NUM_COL*(DIV+BLANK) cycles.
- Frame wrap: on the edge where sel goes NUM_COL-1 -> 0:
  - fim_quadro=1 for one cycle.
  - If pendente=1, active<=pending and pendente<=0; col_dado shows column 0 of the new frame on that edge.
- Load handshake:
  - When frame_ld=1, pendente=0, and the cycle is not a swap cycle: capture frame_in into pending, set pendente=1, and pulse frame_ack the next cycle.
  - frame_ld while pendente=1, or during a swap cycle: ignored, no ack. The sender holds frame_ld until ack.
- Loading while in OCIOSO: pending is captured, and the swap happens immediately on the next cycle, since no scan is running.
- en=0 in any state: next edge goes to OCIOSO, blank=1, sel=0, counters cleared. Buffers and pendente are retained, and any in-progress ack still completes.
- rst mid-scan: all registers return to reset values on that edge; no fim_quadro pulse.
- Simultaneous frame wrap and en=0: en=0 wins. No fim_quadro, no swap.

Decomposition:
- Shared package:
  - State enum {OCIOSO, EXIBE, APAGA}.
  - Constants COL_W=3, ROW_W=8, FRAME_W=64.
  - Function computing prescaler width $clog2(DIV).
- One sub-module, divisor_tick: counter with clear and enable that emits a terminal-count flag. It is instantiated twice, once with DIV and once with BLANK.

Test Plan (DIV=4, BLANK=2, NUM_COL=3):
1. Reset: hold rst for 3 cycles with en=1 -> sel=0, blank=1, col_dado=0, no pulses. Release rst -> blank falls 1 cycle later.
2. Scan: load frame with column bytes 0x81, 0x42, 0x24, then en=1 -> sel sequence 0,1,2,0 with 4 cycles blank=0 and 2 cycles blank=1 per column. col_dado=0x81/0x42/0x24, and sel changes only while blank=1.
3. Frame pulse: continuous scan -> fim_quadro pulses every 18 cycles, exactly on the sel 2->0 edge.
4. Handshake: frame_ld held with pendente=1 -> no ack until the next wrap. Ack arrives 1 cycle after the swap cycle, and the new column 0 data appears at the wrap.
5. en drop mid-EXIBE at sel=1 -> next cycle blank=1, sel=0. Re-enable -> restarts at column 0 with the full 4-cycle display.
6. rst asserted during APAGA of column 2 -> no fim_quadro, all outputs at reset values, buffers cleared (col_dado=0 after restart).

Source files
------------

// File: rtl/gerador_varredura_pkg.sv
// Shared definitions for the LED-matrix column-scan sequencer.
// Contents: scan state enum, bus widths, a counter-width helper
// and a column-extraction helper for a packed 64-bit frame.
package gerador_varredura_pkg;

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXIBE  = 2'd1,
    APAGA  = 2'd2
  } estado_t;

  localparam int COL_W   = 3;
  localparam int ROW_W   = 8;
  localparam int FRAME_W = 64;

  // Width of a counter that spans 0..div-1; never narrower than one bit.
  function automatic int presc_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Column k of a frame occupies bits [8k+7:8k].
  function automatic logic [ROW_W-1:0] col_of(input logic [FRAME_W-1:0] f,
                                               input logic [COL_W-1:0]   k);
    return f[{k, 3'b000} +: ROW_W];
  endfunction

endpackage

// File: rtl/gerador_varredura_if.sv
// Bus between a frame source / display driver and the scan sequencer.
// Signals:
//   en          scan enable
//   frame_ld    frame load request, held by the sender until frame_ack
//   frame_in    64-bit frame, column k = bits [8k+7:8k]
//   frame_ack   one-cycle capture acknowledge
//   sel         column index for the 3-to-8 column decoder
//   col_dado    row pattern of the selected column
//   blank       column drivers off
//   fim_quadro  one-cycle frame-wrap pulse
// master = frame source/driver side, slave = sequencer side.
interface gerador_varredura_if;
  import gerador_varredura_pkg::*;

  logic               en;
  logic               frame_ld;
  logic [FRAME_W-1:0] frame_in;
  logic               frame_ack;
  logic [COL_W-1:0]   sel;
  logic [ROW_W-1:0]   col_dado;
  logic               blank;
  logic               fim_quadro;

  modport master (
    output en, frame_ld, frame_in,
    input  frame_ack, sel, col_dado, blank, fim_quadro
  );

  modport slave (
    input  en, frame_ld, frame_in,
    output frame_ack, sel, col_dado, blank, fim_quadro
  );

endinterface

// File: rtl/gerador_varredura_divisor_tick.sv
// Modulo-MOD counter with synchronous clear and count enable.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr_i     forces the count to 0 (has priority over en_i)
//   en_i      advance the count, wrapping MOD-1 -> 0
//   tc_o      count is at MOD-1 (terminal count)
module divisor_tick
  import gerador_varredura_pkg::*;
#(
  parameter int MOD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int             W   = presc_w(MOD);
  localparam logic [W-1:0]   ULT = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = (cnt_q == ULT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tc_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gerador_varredura.sv
// Column-scan sequencer for an 8x8 LED matrix.
// Lights one column for DIV cycles, blanks for BLANK cycles while the
// column index moves on, and wraps after NUM_COL columns. A 64-bit frame
// is loaded into a pending buffer by a request/ack handshake and copied
// into the displayed buffer only at a frame wrap (or at once when idle).
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   bus       gerador_varredura_if.slave (see interface for signal list)
module gerador_varredura
  import gerador_varredura_pkg::*;
#(
  parameter int DIV     = 50000,
  parameter int BLANK   = 2,
  parameter int NUM_COL = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gerador_varredura_if.slave    bus
);

  localparam logic [COL_W-1:0] ULT_COL = COL_W'(NUM_COL - 1);

  estado_t            estado_q, estado_d;
  logic [COL_W-1:0]   sel_q, sel_d;
  logic [ROW_W-1:0]   col_q, col_d;
  logic               blank_q, blank_d;
  logic               ack_q, ack_d;
  logic               fim_q, fim_d;
  logic               avanca_q, avanca_d;
  logic [FRAME_W-1:0] ativo_q, ativo_d;
  logic [FRAME_W-1:0] pend_q, pend_d;
  logic               pendente_q, pendente_d;
  logic               troca;
  logic               presc_tc, blank_tc;

  // Both counters are held at zero outside their own state, so every
  // display and every blanking interval starts from a fresh count.
  divisor_tick #(.MOD(DIV)) u_presc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!bus.en || estado_q != EXIBE),
    .en_i  (estado_q == EXIBE),
    .tc_o  (presc_tc)
  );

  divisor_tick #(.MOD(BLANK)) u_apaga (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!bus.en || estado_q != APAGA),
    .en_i  (estado_q == APAGA),
    .tc_o  (blank_tc)
  );

  always_comb begin
    estado_d   = estado_q;
    sel_d      = sel_q;
    blank_d    = blank_q;
    fim_d      = 1'b0;
    ack_d      = 1'b0;
    ativo_d    = ativo_q;
    pend_d     = pend_q;
    pendente_d = pendente_q;
    troca      = 1'b0;

    case (estado_q)
      OCIOSO: begin
        // No scan running: a pending frame can be shown right away.
        troca = pendente_q;
        if (bus.en) begin
          estado_d = EXIBE;
          blank_d  = 1'b0;
        end
      end
      EXIBE: begin
        if (presc_tc) begin
          estado_d = APAGA;
          blank_d  = 1'b1;
        end
      end
      APAGA: begin
        // Column moves at the end of the first blank cycle, so sel is
        // settled before the drivers come back on.
        if (avanca_q) begin
          if (sel_q == ULT_COL) begin
            sel_d = '0;
            fim_d = 1'b1;
            troca = pendente_q;
          end else begin
            sel_d = sel_q + COL_W'(1);
          end
        end
        if (blank_tc) begin
          estado_d = EXIBE;
          blank_d  = 1'b0;
        end
      end
      default: estado_d = OCIOSO;
    endcase

    // Dropping enable beats a simultaneous wrap: no pulse, no swap.
    if (!bus.en) begin
      estado_d = OCIOSO;
      blank_d  = 1'b1;
      sel_d    = '0;
      fim_d    = 1'b0;
      if (estado_q != OCIOSO) troca = 1'b0;
    end

    avanca_d = (estado_q == EXIBE) && (estado_d == APAGA);

    if (troca) begin
      ativo_d    = pend_q;
      pendente_d = 1'b0;
    end

    if (bus.frame_ld && !pendente_q && !troca) begin
      pend_d     = bus.frame_in;
      pendente_d = 1'b1;
      ack_d      = 1'b1;
    end

    col_d = col_of(troca ? pend_q : ativo_q, sel_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= OCIOSO;
      sel_q      <= '0;
      col_q      <= '0;
      blank_q    <= 1'b1;
      ack_q      <= 1'b0;
      fim_q      <= 1'b0;
      avanca_q   <= 1'b0;
      ativo_q    <= '0;
      pend_q     <= '0;
      pendente_q <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      sel_q      <= sel_d;
      col_q      <= col_d;
      blank_q    <= blank_d;
      ack_q      <= ack_d;
      fim_q      <= fim_d;
      avanca_q   <= avanca_d;
      ativo_q    <= ativo_d;
      pend_q     <= pend_d;
      pendente_q <= pendente_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.col_dado   = col_q;
  assign bus.blank      = blank_q;
  assign bus.frame_ack  = ack_q;
  assign bus.fim_quadro = fim_q;

endmodule

// File: tb/tb_gerador_varredura.sv
// Directed bench for gerador_varredura with DIV=4, BLANK=2, NUM_COL=3.
// A cycle model of the scan pushes the expected outputs for each edge
// into a queue when the inputs are driven; they are popped and compared
// once the DUT has produced that edge's outputs.
module tb_gerador_varredura;
  import gerador_varredura_pkg::*;

  localparam int DIV     = 4;
  localparam int BLANK   = 2;
  localparam int NUM_COL = 3;

  localparam logic [63:0] F1 = 64'h0000_0000_0024_4281;
  localparam logic [63:0] F2 = 64'h0000_0000_00C3_A55A;
  localparam logic [63:0] F3 = 64'h0000_0000_0018_7E3C;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] col;
    logic       blank;
    logic       ack;
    logic       fim;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  gerador_varredura_if bus ();

  gerador_varredura #(.DIV(DIV), .BLANK(BLANK), .NUM_COL(NUM_COL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  exp_t sb[$];

  // reference model state
  logic        m_on;
  int          m_phase;
  int          m_sel;
  logic [63:0] m_act, m_pend;
  logic        m_pendente;
  logic [2:0]  prev_sel;

  task automatic chk(input string nome, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", nome, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    logic troca, vira, aceita;
    troca = 1'b0; vira = 1'b0; aceita = 1'b0;
    if (rst) begin
      m_on = 1'b0; m_phase = 0; m_sel = 0;
      m_act = '0; m_pend = '0; m_pendente = 1'b0;
    end else begin
      if (!m_on) begin
        troca = m_pendente;
        if (bus.en) begin m_on = 1'b1; m_phase = 0; end
      end else if (!bus.en) begin
        m_on = 1'b0; m_phase = 0; m_sel = 0;
      end else begin
        if (m_phase == DIV) begin
          if (m_sel == NUM_COL - 1) begin
            m_sel = 0; vira = 1'b1; troca = m_pendente;
          end else begin
            m_sel++;
          end
        end
        m_phase = (m_phase == DIV + BLANK - 1) ? 0 : m_phase + 1;
      end
      aceita = bus.frame_ld && !m_pendente && !troca;
      if (troca)  begin m_act = m_pend; m_pendente = 1'b0; end
      if (aceita) begin m_pend = bus.frame_in; m_pendente = 1'b1; end
    end
    e.sel   = 3'(m_sel);
    e.blank = !m_on || (m_phase >= DIV);
    e.col   = m_act[8*m_sel +: 8];
    e.fim   = vira;
    e.ack   = aceita;
    sb.push_back(e);

    @(posedge clk); #1; cyc++;

    e = sb.pop_front();
    chk("sel",        64'(bus.sel),        64'(e.sel));
    chk("col_dado",   64'(bus.col_dado),   64'(e.col));
    chk("blank",      64'(bus.blank),      64'(e.blank));
    chk("frame_ack",  64'(bus.frame_ack),  64'(e.ack));
    chk("fim_quadro", 64'(bus.fim_quadro), 64'(e.fim));
    if (bus.sel !== prev_sel) chk("sel_muda_so_em_blank", 64'(bus.blank), 64'd1);
    prev_sel = bus.sel;
  endtask

  // Hold frame_ld until the DUT acknowledges, bounded by max_ciclos.
  task automatic carrega(input logic [63:0] f, input int max_ciclos, input string nome);
    int n;
    n = 0;
    bus.frame_in = f;
    bus.frame_ld = 1'b1;
    while (!bus.frame_ack && n < max_ciclos) begin step(); n++; end
    chk(nome, 64'(bus.frame_ack), 64'd1);
    bus.frame_ld = 1'b0;
  endtask

  // modo 0: wait for column alvo lit; modo 1: wait for blank.
  task automatic espera(input int modo, input int alvo, input string nome);
    int n;
    n = 0;
    while (n < 60 && !((modo == 0) ? (int'(bus.sel) == alvo && !bus.blank) : bus.blank)) begin
      step(); n++;
    end
    chk(nome, 64'(n < 60), 64'd1);
  endtask

  initial begin
    int last_fim, nf;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.frame_ld = 1'b0;
    bus.frame_in = '0;
    prev_sel = 3'd0;

    // 1. reset held with en=1, then released
    repeat (3) step();
    chk("reset_blank", 64'(bus.blank), 64'd1);
    rst = 1'b0;
    step();
    chk("blank_cai_apos_reset", 64'(bus.blank), 64'd0);
    repeat (3) step();

    // 2. idle, load F1, then scan
    bus.en = 1'b0;
    step();
    carrega(F1, 10, "ack_ocioso");
    bus.en = 1'b1;
    step();
    chk("col0_F1", 64'(bus.col_dado), 64'h81);

    // 3. continuous scan, frame pulse every 18 cycles on sel 2->0
    last_fim = -1; nf = 0;
    for (int i = 0; i < 45; i++) begin
      step();
      if (bus.fim_quadro) begin
        chk("fim_em_sel0", 64'(bus.sel), 64'd0);
        if (last_fim >= 0) chk("periodo_quadro", 64'(cyc - last_fim), 64'd18);
        last_fim = cyc; nf++;
      end
    end
    chk("num_pulsos_quadro", 64'(nf >= 2), 64'd1);

    // 4. F2 accepted at once; F3 waits for the next wrap
    carrega(F2, 5, "ack_F2");
    step();
    carrega(F3, 40, "ack_F3_apos_troca");
    repeat (4) step();

    // wrap coinciding with en=0: no pulse, no swap (F3 still pending)
    espera(0, 2, "espera_col2_a");
    espera(1, 0, "espera_apaga_a");
    bus.en = 1'b0;
    step();
    bus.en = 1'b1;
    repeat (8) step();

    // 5. en drop in the middle of column 1, then restart
    espera(0, 1, "espera_col1");
    step();
    bus.en = 1'b0;
    step();
    chk("en0_blank", 64'(bus.blank), 64'd1);
    bus.en = 1'b1;
    repeat (12) step();

    // 6. reset during blanking of column 2
    espera(0, 2, "espera_col2_b");
    espera(1, 0, "espera_apaga_b");
    rst = 1'b1;
    step();
    chk("rst_sem_fim", 64'(bus.fim_quadro), 64'd0);
    rst = 1'b0;
    repeat (8) step();
    chk("buffers_limpos", 64'(bus.col_dado), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
